mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the processor's single 16-bit memory port. The instruction-fetch path (`if_*`) and the load/store path of the execute stage (`dm_*`) share one memory interface. The block grants one transaction at a time, holds the memory request until the memory acknowledges it, and returns read data or a write acknowledge to the owner. It sits between the fetch/decode/execute control and the memory model. A streak limit keeps fetch from starving, and a watchdog aborts transactions the memory never answers.

---
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for a single memory port.
// Instruction fetch and data load/store share one memory interface. One
// transaction is granted at a time, the memory request is held until the
// memory answers, and the result goes back to whichever side owns the port.
// A data-grant streak limit keeps fetch from starving. A watchdog aborts a
// transaction that the memory never acknowledges.
module mem_arbiter #(
    parameter int AW             = 16,
    parameter int DW             = 16,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    // instruction-fetch requester
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    // load/store requester
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    // memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    // status
    output logic          err,
    output logic          busy
);

    // The counters are sized so they can hold their terminal values exactly.
    localparam int SW = $clog2(MAX_DATA_BURST + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);
    localparam logic [WW-1:0] WDOG_MAX   = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } state_t;

    state_t state, state_d;

    logic [SW-1:0] streak, streak_d;
    logic [WW-1:0] wdog, wdog_d;

    // next values of the registered outputs
    logic          if_gnt_d, dm_gnt_d;
    logic          if_valid_d, dm_valid_d;
    logic [DW-1:0] if_rdata_d, dm_rdata_d;
    logic          mem_en_d, mem_we_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;
    logic          err_d, busy_d;

    // arbitration and completion decisions
    logic          pick_dm, pick_if;
    logic          in_wait, done, timed_out;
    logic [DW-1:0] done_rdata;

    // Data normally wins a collision; once data has been granted
    // MAX_DATA_BURST times in a row while fetch was waiting, fetch goes next.
    assign pick_dm = (state == IDLE) && en && dm_req &&
                     !(if_req && (streak == STREAK_MAX));
    assign pick_if = (state == IDLE) && en && if_req && !pick_dm;

    // A transaction ends on the memory acknowledge or when the watchdog runs
    // out; an acknowledge in the final watchdog cycle still counts as success.
    assign in_wait    = (state == IF_WAIT) || (state == DM_WAIT);
    assign timed_out  = in_wait && !mem_ready && (wdog == WDOG_MAX);
    assign done       = in_wait && (mem_ready || (wdog == WDOG_MAX));
    assign done_rdata = (mem_ready && !mem_we) ? mem_rdata : '0;

    // Next-state, counter and output computation for the sequencer.
    always_comb begin
        state_d     = state;
        streak_d    = streak;
        wdog_d      = wdog;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state)
            IDLE: begin
                if (pick_dm) begin
                    state_d     = DM_WAIT;
                    dm_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    wdog_d      = '0;
                    // only back-to-back data grants against a waiting fetch
                    // count toward the streak
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak != STREAK_MAX) begin
                        streak_d = streak + SW'(1);
                    end
                end else if (pick_if) begin
                    state_d     = IF_WAIT;
                    if_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    wdog_d      = '0;
                    streak_d    = '0;
                end
            end

            IF_WAIT, DM_WAIT: begin
                if (done) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    err_d    = timed_out;
                    if (state == IF_WAIT) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = done_rdata;
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = done_rdata;
                    end
                end else begin
                    wdog_d = wdog + WW'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Streak and watchdog counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
            wdog   <= '0;
        end else begin
            streak <= streak_d;
            wdog   <= wdog_d;
        end
    end

    // Registered outputs; reset drops the memory request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if_gnt    <= if_gnt_d;
            dm_gnt    <= dm_gnt_d;
            if_valid  <= if_valid_d;
            dm_valid  <= dm_valid_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            err       <= err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// plus a transaction-level reference model compared every cycle.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int MDB = 4;
    localparam int TMO = 15;

    logic          clk, reset, en;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_valid;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt, dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err, busy;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_BURST(MDB), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .en(en),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // m_owner: 0 = port free, 1 = fetch owns it, 2 = data owns it
    // m_len:   number of cycles the memory request has been up so far
    int            m_owner, m_len, m_streak;
    logic          m_we;
    logic          e_if_gnt, e_dm_gnt, e_if_valid, e_dm_valid, e_err, e_busy;
    logic          e_mem_en, e_mem_we;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_if_rdata, e_dm_rdata;

    wire m_free      = (m_owner == 0);
    wire m_fetch_due = (m_streak >= MDB);
    wire m_take_dm   = m_free && en && dm_req && !(if_req && m_fetch_due);
    wire m_take_if   = m_free && en && if_req && !m_take_dm;
    wire m_finish    = !m_free && (mem_ready || (m_len == TMO + 1));
    wire [DW-1:0] m_result = (mem_ready && !m_we) ? mem_rdata : '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner <= 0; m_len <= 0; m_streak <= 0; m_we <= 1'b0;
            e_if_gnt <= 0; e_dm_gnt <= 0; e_if_valid <= 0; e_dm_valid <= 0;
            e_err <= 0; e_busy <= 0; e_mem_en <= 0; e_mem_we <= 0;
            e_mem_addr <= '0; e_mem_wdata <= '0; e_if_rdata <= '0; e_dm_rdata <= '0;
        end else begin
            e_if_gnt   <= m_take_if;
            e_dm_gnt   <= m_take_dm;
            e_if_valid <= m_finish && (m_owner == 1);
            e_dm_valid <= m_finish && (m_owner == 2);
            e_err      <= m_finish && !mem_ready;
            if (m_take_dm) begin
                m_owner <= 2; m_len <= 1; m_we <= dm_we;
                e_mem_en <= 1; e_mem_we <= dm_we;
                e_mem_addr <= dm_addr; e_mem_wdata <= dm_wdata;
                m_streak <= if_req ? ((m_streak + 1 > MDB) ? MDB : m_streak + 1) : 0;
                e_busy <= 1;
            end else if (m_take_if) begin
                m_owner <= 1; m_len <= 1; m_we <= 1'b0;
                e_mem_en <= 1; e_mem_we <= 0; e_mem_addr <= if_addr;
                m_streak <= 0;
                e_busy <= 1;
            end else if (m_finish) begin
                if (m_owner == 1) e_if_rdata <= m_result;
                else              e_dm_rdata <= m_result;
                m_owner <= 0; e_mem_en <= 0; e_mem_we <= 0; e_busy <= 0;
            end else if (!m_free) begin
                m_len <= m_len + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk1("if_gnt", if_gnt, e_if_gnt);
        chk1("dm_gnt", dm_gnt, e_dm_gnt);
        chk1("if_valid", if_valid, e_if_valid);
        chk1("dm_valid", dm_valid, e_dm_valid);
        chk1("err", err, e_err);
        chk1("busy", busy, e_busy);
        chk1("mem_en", mem_en, e_mem_en);
        chk1("mem_we", mem_we, e_mem_we);
        chk1("gnt_exclusive", if_gnt & dm_gnt, 1'b0);
        if (e_mem_en) chk16("mem_addr", mem_addr, e_mem_addr);
        if (e_mem_en && e_mem_we) chk16("mem_wdata", mem_wdata, e_mem_wdata);
        if (e_if_valid) chk16("if_rdata", if_rdata, e_if_rdata);
        if (e_dm_valid) chk16("dm_rdata", dm_rdata, e_dm_rdata);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got stuck expected done");
        $fatal(1, "timeout");
    end

    initial begin
        string seq;
        int    run, maxrun, ngr, cnt;
        logic  saw_valid;

        reset = 1'b1; en = 1'b1;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        tick(); tick();
        chk1("reset_mem_en", mem_en, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk16("reset_mem_addr", mem_addr, 16'h0000);
        reset = 1'b0;
        tick();

        // single fetch, zero-wait memory
        if_req = 1; if_addr = 16'h0010; mem_ready = 1; mem_rdata = 16'hBEEF;
        tick();
        chk1("fetch_gnt", if_gnt, 1'b1);
        chk1("fetch_mem_en", mem_en, 1'b1);
        chk16("fetch_addr", mem_addr, 16'h0010);
        if_req = 0;
        tick();
        chk1("fetch_valid", if_valid, 1'b1);
        chk16("fetch_rdata", if_rdata, 16'hBEEF);
        chk1("fetch_busy_low", busy, 1'b0);
        mem_ready = 0;
        tick();

        // data write with three memory wait cycles
        dm_req = 1; dm_we = 1; dm_addr = 16'h2000; dm_wdata = 16'h1234;
        tick();
        chk1("wr_gnt", dm_gnt, 1'b1);
        dm_req = 0;
        for (int i = 1; i <= 4; i++) begin
            chk1("wr_mem_en", mem_en, 1'b1);
            chk1("wr_mem_we", mem_we, 1'b1);
            chk16("wr_addr", mem_addr, 16'h2000);
            chk16("wr_wdata", mem_wdata, 16'h1234);
            if (i == 4) mem_ready = 1;
            tick();
        end
        chk1("wr_valid", dm_valid, 1'b1);
        chk16("wr_rdata", dm_rdata, 16'h0000);
        chk1("wr_err", err, 1'b0);
        mem_ready = 0; dm_we = 0;
        tick();

        // starvation guard: both requesters hold requests, zero-wait memory
        if_req = 1; if_addr = 16'h0100; dm_req = 1; dm_we = 0; dm_addr = 16'h4000;
        mem_ready = 1; mem_rdata = 16'hA5A5;
        seq = ""; run = 0; maxrun = 0; ngr = 0;
        for (int c = 0; c < 60 && ngr < 10; c++) begin
            tick();
            mem_rdata = mem_rdata + 16'h0101;
            if (dm_gnt) begin
                seq = {seq, "D"}; ngr++; run++;
                if (run > maxrun) maxrun = run;
            end
            if (if_gnt) begin
                seq = {seq, "F"}; ngr++; run = 0;
            end
        end
        n_vec++;
        if (seq != "DDDDFDDDDF") begin
            n_err++;
            $display("FAIL grant_order: got %s expected DDDDFDDDDF", seq);
        end
        chkint("max_data_run", maxrun, MDB);
        if_req = 0; dm_req = 0;
        tick(); tick();
        mem_ready = 0;
        tick();

        // watchdog abort on a read the memory never answers
        dm_req = 1; dm_we = 0; dm_addr = 16'h3000;
        tick();
        dm_req = 0;
        cnt = 0;
        while (mem_en && cnt < 40) begin
            cnt++;
            tick();
        end
        chkint("tmo_mem_en_cycles", cnt, TMO + 1);
        chk1("tmo_valid", dm_valid, 1'b1);
        chk1("tmo_err", err, 1'b1);
        chk16("tmo_rdata", dm_rdata, 16'h0000);
        chk1("tmo_busy", busy, 1'b0);
        tick();

        // reset in the second wait cycle of a fetch
        if_req = 1; if_addr = 16'h0040; mem_ready = 0;
        tick();
        if_req = 0;
        tick();
        #2 reset = 1;
        #1;
        chk1("rst_mem_en_async", mem_en, 1'b0);
        chk1("rst_busy_async", busy, 1'b0);
        chk1("rst_gnt", if_gnt, 1'b0);
        mem_ready = 1; mem_rdata = 16'hDEAD;
        tick(); tick();
        reset = 0;
        saw_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (if_valid) saw_valid = 1;
        end
        chk1("rst_no_valid", saw_valid, 1'b0);
        if_req = 1; if_addr = 16'h0050; mem_rdata = 16'h5555;
        tick();
        chk1("post_rst_gnt", if_gnt, 1'b1);
        if_req = 0;
        tick();
        chk1("post_rst_valid", if_valid, 1'b1);
        chk16("post_rst_rdata", if_rdata, 16'h5555);
        mem_ready = 0;
        tick();

        // en gating
        en = 0; if_req = 1; if_addr = 16'h0060; dm_req = 1; dm_we = 0; dm_addr = 16'h6000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("en0_no_gnt", if_gnt | dm_gnt, 1'b0);
        end
        en = 1;
        tick();
        chk1("en1_dm_gnt", dm_gnt, 1'b1);
        dm_req = 0; en = 0;
        tick();
        mem_ready = 1; mem_rdata = 16'h7777;
        tick();
        chk1("en0_inflight_valid", dm_valid, 1'b1);
        chk16("en0_inflight_rdata", dm_rdata, 16'h7777);
        tick();
        chk1("en0_no_if_gnt", if_gnt, 1'b0);
        en = 1;
        tick();
        chk1("en1_if_gnt", if_gnt, 1'b1);
        if_req = 0;
        tick();
        chk1("en1_if_valid", if_valid, 1'b1);
        mem_ready = 0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
